// File: rtl/if_id_stage.sv
// if_id_stage: fetch-to-decode pipeline register with a two-entry skid buffer.
//
// The stage takes instruction/PC pairs from fetch over a valid/ready handshake.
// It holds up to two of them in FIFO order: a head entry that drives the
// outputs and a skid entry. It also pre-decodes the head opcode into the offset
// select and raw 12-bit immediate consumed by sign_extender.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   if_valid/if_ready    fetch handshake (if_ready is a flop output)
//   if_instr, if_pc      offered instruction word and its PC
//   id_ready             downstream consumes the head this cycle
//   flush                drop everything held (taken branch / jump)
//   id_valid             head entry is valid
//   id_instr, id_pc      head instruction word and its PC
//   offset_sel           sign_extender width select for the head instruction
//   imm_field            raw immediate for the head, upper bits zeroed
//   halted               a halt opcode was accepted and intake is stopped

package if_id_pkg;
  typedef enum logic [1:0] {
    NONE      = 2'd0,
    EIGHTBIT  = 2'd1,
    FOURBIT   = 2'd2,
    TWELVEBIT = 2'd3
  } sel_t;
endpackage

module if_id_stage
  import if_id_pkg::*;
#(
  parameter int          INSTR_W     = 16,
  parameter int          PC_W        = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [PC_W-1:0]    if_pc,
  output logic               if_ready,
  input  logic               id_ready,
  input  logic               flush,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output sel_t               offset_sel,
  output logic [11:0]        imm_field,
  output logic               halted
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO, HALT} state_t;

  state_t state, state_next;

  logic               head_valid, head_valid_next;
  logic [INSTR_W-1:0] head_instr, head_instr_next;
  logic [PC_W-1:0]    head_pc,    head_pc_next;
  logic               skid_valid, skid_valid_next;
  logic [INSTR_W-1:0] skid_instr, skid_instr_next;
  logic [PC_W-1:0]    skid_pc,    skid_pc_next;

  logic               if_ready_q;
  logic               halted_q;
  sel_t               sel_q, sel_next;
  logic [11:0]        imm_q, imm_next;

  logic accept, pop, is_halt;

  assign accept  = if_valid && if_ready_q;
  assign pop     = head_valid && id_ready;
  assign is_halt = (if_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

  // Opcode decode table for the sign_extender interface. Bits above the
  // selected immediate width are forced to zero.
  function automatic void decode(input  logic [INSTR_W-1:0] w,
                                 output sel_t               sel,
                                 output logic [11:0]        imm);
    sel = NONE;
    imm = {4'h0, w[7:0]};
    casez (w[INSTR_W-1 -: 4])
      4'b0000: begin sel = NONE;      imm = 12'h000;          end
      4'b01??: begin sel = EIGHTBIT;  imm = {4'h0, w[7:0]};   end
      4'b10??: begin sel = FOURBIT;   imm = {8'h00, w[3:0]};  end
      4'b1100: begin sel = TWELVEBIT; imm = w[11:0];          end
      default: begin sel = NONE;      imm = {4'h0, w[7:0]};   end
    endcase
  endfunction

  // Intake control. Accepting a halt word enqueues it like any other word
  // but parks the FSM in HALT, which only a flush leaves; the held entries
  // keep draining while parked. TWO never sees an accept because if_ready
  // is low there.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_next = is_halt ? HALT : ONE;
        ONE: begin
          if (accept && is_halt)   state_next = HALT;
          else if (accept && !pop) state_next = TWO;
          else if (pop && !accept) state_next = EMPTY;
        end
        TWO:     if (pop) state_next = ONE;
        HALT:    state_next = HALT;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Two-entry FIFO datapath. A pop promotes the skid word to the head, so
  // the skid word always issues after the head. A flush clears both entries
  // back to their reset contents, which ignores any same-cycle accept or pop.
  always_comb begin
    head_valid_next = head_valid;
    head_instr_next = head_instr;
    head_pc_next    = head_pc;
    skid_valid_next = skid_valid;
    skid_instr_next = skid_instr;
    skid_pc_next    = skid_pc;
    if (flush) begin
      head_valid_next = 1'b0;
      head_instr_next = '0;
      head_pc_next    = '0;
      skid_valid_next = 1'b0;
      skid_instr_next = '0;
      skid_pc_next    = '0;
    end else if (pop) begin
      if (skid_valid) begin
        head_instr_next = skid_instr;
        head_pc_next    = skid_pc;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        head_instr_next = if_instr;
        head_pc_next    = if_pc;
      end else begin
        head_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (head_valid) begin
        skid_valid_next = 1'b1;
        skid_instr_next = if_instr;
        skid_pc_next    = if_pc;
      end else begin
        head_valid_next = 1'b1;
        head_instr_next = if_instr;
        head_pc_next    = if_pc;
      end
    end
  end

  // The decode is computed from the word entering the head. Its result
  // therefore appears in the same cycle as that word.
  always_comb begin
    decode(head_instr_next, sel_next, imm_next);
  end

  // State, storage and registered outputs. The ready and halted outputs are
  // computed from the next state so that each one is a plain flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      head_valid <= 1'b0;
      head_instr <= '0;
      head_pc    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      if_ready_q <= 1'b1;
      halted_q   <= 1'b0;
      sel_q      <= NONE;
      imm_q      <= 12'h000;
    end else begin
      state      <= state_next;
      head_valid <= head_valid_next;
      head_instr <= head_instr_next;
      head_pc    <= head_pc_next;
      skid_valid <= skid_valid_next;
      skid_instr <= skid_instr_next;
      skid_pc    <= skid_pc_next;
      if_ready_q <= (state_next == EMPTY) || (state_next == ONE);
      halted_q   <= (state_next == HALT);
      sel_q      <= sel_next;
      imm_q      <= imm_next;
    end
  end

  assign if_ready   = if_ready_q;
  assign halted     = halted_q;
  assign id_valid   = head_valid;
  assign id_instr   = head_instr;
  assign id_pc      = head_pc;
  assign offset_sel = sel_q;
  assign imm_field  = imm_q;

endmodule
